// File: rtl/dispatch_pkg.sv
// rtl/dispatch_pkg.sv - shared defaults, index type and FSM states for the plate frame dispatcher
package dispatch_pkg;

    localparam int DEF_NUM_BOARDS = 5;
    localparam int DEF_FRAME_W    = 1024;
    localparam int DEF_TS_W       = 19;
    localparam int DEF_DROP_W     = 8;

    localparam int BOARD_IDX_W = $clog2(DEF_NUM_BOARDS);

    typedef logic [BOARD_IDX_W-1:0] board_idx_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick among pending board slots
//
// Ports:
//   pend     in   N       pending flag per board
//   rr_last  in   IDX_W   board granted most recently
//   grant    out  IDX_W   first pending board after rr_last (wrapping); 0 when none
//   any      out  1       at least one board pending
module rr_arbiter
    import dispatch_pkg::*;
#(
    parameter int N     = DEF_NUM_BOARDS,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     pend,
    input  logic [IDX_W-1:0] rr_last,
    output logic [IDX_W-1:0] grant,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    // Scan from the farthest candidate back to the nearest so the last hit
    // written is the first pending board after rr_last.
    always_comb begin
        grant = '0;
        cand  = '0;
        for (int i = N; i >= 1; i--) begin
            cand = IDX_W'((int'(rr_last) + i) % N);
            if (pend[cand]) begin
                grant = cand;
            end
        end
    end

    assign any = |pend;

endmodule

// File: rtl/plate_frame_dispatcher.sv
// rtl/plate_frame_dispatcher.sv - buffers one camera frame per board and dispatches them round-robin
//
// Ports:
//   clk, reset   clock and synchronous active-high reset
//   in_frame     NUM_BOARDS*FRAME_W  board b frame at [b*FRAME_W +: FRAME_W]
//   in_active    NUM_BOARDS          per-board capture strobe, sampled every clk
//   out_frame    FRAME_W             presented frame
//   out_sel      NUM_BOARDS          one-hot source board, 0 when out_valid is low
//   out_ts       TS_W                tick at capture of the presented frame
//   out_valid    1                   out_* hold a frame
//   out_ready    1                   recognizer accepts (transfer = out_valid & out_ready)
//   drop_count   DROP_W              frames overwritten before dispatch, saturating
//   busy         1                   any slot pending or out_valid high
module plate_frame_dispatcher
    import dispatch_pkg::*;
#(
    parameter int NUM_BOARDS = DEF_NUM_BOARDS,
    parameter int FRAME_W    = DEF_FRAME_W,
    parameter int TS_W       = DEF_TS_W,
    parameter int DROP_W     = DEF_DROP_W
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_BOARDS*FRAME_W-1:0] in_frame,
    input  logic [NUM_BOARDS-1:0]         in_active,
    output logic [FRAME_W-1:0]            out_frame,
    output logic [NUM_BOARDS-1:0]         out_sel,
    output logic [TS_W-1:0]               out_ts,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DROP_W-1:0]             drop_count,
    output logic                          busy
);

    localparam int IDX_W = $clog2(NUM_BOARDS);

    logic [FRAME_W-1:0]    slot_q [NUM_BOARDS];
    logic [TS_W-1:0]       ts_q   [NUM_BOARDS];
    logic [NUM_BOARDS-1:0] pend_q, pend_d;
    logic [TS_W-1:0]       tick_q;
    logic [DROP_W-1:0]     drop_q, drop_d;
    logic [IDX_W-1:0]      rr_last_q;
    logic [IDX_W-1:0]      grant;
    logic                  any_pend;
    logic [NUM_BOARDS-1:0] load_hot;

    logic [FRAME_W-1:0]    out_frame_q;
    logic [NUM_BOARDS-1:0] out_sel_q;
    logic [TS_W-1:0]       out_ts_q;
    logic                  out_valid_q;

    state_t state_q, state_d;
    logic   load, xfer;

    rr_arbiter #(
        .N     (NUM_BOARDS),
        .IDX_W (IDX_W)
    ) u_arb (
        .pend    (pend_q),
        .rr_last (rr_last_q),
        .grant   (grant),
        .any     (any_pend)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        xfer    = 1'b0;
        case (state_q)
            IDLE: begin
                if (any_pend) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (out_ready) begin
                    xfer    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign load_hot = load ? (NUM_BOARDS'(1) << grant) : '0;

    // A strobe on the board being loaded this edge refills its slot without
    // counting a drop: the load consumes the old frame, the new one stays pending.
    always_comb begin
        pend_d = (pend_q & ~load_hot) | in_active;
        drop_d = drop_q;
        for (int b = 0; b < NUM_BOARDS; b++) begin
            if (in_active[b] && pend_q[b] && !load_hot[b] && (drop_d != '1)) begin
                drop_d = drop_d + DROP_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pend_q      <= '0;
            tick_q      <= '0;
            drop_q      <= '0;
            rr_last_q   <= IDX_W'(NUM_BOARDS - 1);
            out_frame_q <= '0;
            out_sel_q   <= '0;
            out_ts_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tick_q  <= tick_q + TS_W'(1);
            drop_q  <= drop_d;
            if (load) begin
                out_frame_q <= slot_q[grant];
                out_ts_q    <= ts_q[grant];
                out_sel_q   <= load_hot;
                out_valid_q <= 1'b1;
                rr_last_q   <= grant;
            end else if (xfer) begin
                out_sel_q   <= '0;
                out_valid_q <= 1'b0;
            end
        end
    end

    // Slot contents are qualified by pend_q, so they need no reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BOARDS; b++) begin
            if (in_active[b]) begin
                slot_q[b] <= in_frame[b*FRAME_W +: FRAME_W];
                ts_q[b]   <= tick_q;
            end
        end
    end

    assign out_frame  = out_frame_q;
    assign out_sel    = out_sel_q;
    assign out_ts     = out_ts_q;
    assign out_valid  = out_valid_q;
    assign drop_count = drop_q;
    assign busy       = (|pend_q) | out_valid_q;

endmodule

// File: tb/tb_plate_frame_dispatcher.sv
// tb/tb_plate_frame_dispatcher.sv - directed self-checking bench for plate_frame_dispatcher
module tb_plate_frame_dispatcher;

    localparam int NB  = 5;
    localparam int FW  = 1024;
    localparam int TW  = 19;
    localparam int DW  = 8;
    localparam int FW2 = 16;
    localparam int TW2 = 4;
    localparam int DW2 = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NB*FW-1:0] in_frame = '0;
    logic [NB-1:0]    in_active = '0;
    logic [FW-1:0]    out_frame;
    logic [NB-1:0]    out_sel;
    logic [TW-1:0]    out_ts;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [DW-1:0]    drop_count;
    logic             busy;

    logic [NB*FW2-1:0] in_frame2 = '0;
    logic [NB-1:0]     in_active2 = '0;
    logic [FW2-1:0]    out_frame2;
    logic [NB-1:0]     out_sel2;
    logic [TW2-1:0]    out_ts2;
    logic              out_valid2;
    logic              out_ready2 = 1'b0;
    logic [DW2-1:0]    drop_count2;
    logic              busy2;

    plate_frame_dispatcher #(.NUM_BOARDS(NB), .FRAME_W(FW), .TS_W(TW), .DROP_W(DW)) dut (
        .clk(clk), .reset(reset), .in_frame(in_frame), .in_active(in_active),
        .out_frame(out_frame), .out_sel(out_sel), .out_ts(out_ts), .out_valid(out_valid),
        .out_ready(out_ready), .drop_count(drop_count), .busy(busy)
    );

    plate_frame_dispatcher #(.NUM_BOARDS(NB), .FRAME_W(FW2), .TS_W(TW2), .DROP_W(DW2)) dut2 (
        .clk(clk), .reset(reset), .in_frame(in_frame2), .in_active(in_active2),
        .out_frame(out_frame2), .out_sel(out_sel2), .out_ts(out_ts2), .out_valid(out_valid2),
        .out_ready(out_ready2), .drop_count(drop_count2), .busy(busy2)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int tb_tick = 0;

    // Reference tick: value the DUT's tick holds between two rising edges.
    always @(posedge clk) tb_tick <= reset ? 0 : tb_tick + 1;

    task automatic check(input string tag, input logic [1023:0] act, input logic [1023:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (low 128 bits)", tag, act[127:0], exp[127:0]);
        end
    endtask

    function automatic logic [FW-1:0] pat(input logic [7:0] b);
        return {128{b}};
    endfunction

    task automatic set_frame(input int b, input logic [FW-1:0] f);
        in_frame[b*FW +: FW] = f;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset      = 1'b1;
        in_active  = '0;
        in_active2 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    logic [NB-1:0]  seq_a [6] = '{5'b00001, 5'b00000, 5'b00010, 5'b00000, 5'b10000, 5'b00000};
    logic [NB-1:0]  seq_b [4] = '{5'b00001, 5'b00000, 5'b10000, 5'b00000};
    logic [DW2-1:0] sat_exp [7] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    int ets, ets3, errs;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // reset state
        do_reset();
        check("rst valid", out_valid, 0);
        check("rst sel", out_sel, 0);
        check("rst frame", out_frame, 0);
        check("rst ts", out_ts, 0);
        check("rst drop", drop_count, 0);
        check("rst busy", busy, 0);

        // 1 single frame on board 2
        out_ready = 1'b1;
        set_frame(2, pat(8'hA5));
        in_active = 5'b00100;
        ets = tb_tick;
        @(negedge clk);
        in_active = '0;
        check("t1 valid early", out_valid, 0);
        check("t1 busy pend", busy, 1);
        @(negedge clk);
        check("t1 valid", out_valid, 1);
        check("t1 sel", out_sel, 5'b00100);
        check("t1 ts", out_ts, ets);
        check("t1 frame", out_frame, pat(8'hA5));
        @(negedge clk);
        check("t1 valid after", out_valid, 0);
        check("t1 sel after", out_sel, 0);
        check("t1 busy after", busy, 0);
        check("t1 ts hold", out_ts, ets);

        // 2 round-robin
        do_reset();
        out_ready = 1'b1;
        set_frame(0, pat(8'h10));
        set_frame(1, pat(8'h11));
        set_frame(4, pat(8'h14));
        in_active = 5'b10011;
        ets = tb_tick;
        @(negedge clk);
        in_active = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t2 order a", out_sel, seq_a[i]);
            if (i == 4) begin
                check("t2 frame4", out_frame, pat(8'h14));
                check("t2 ts4", out_ts, ets);
            end
        end
        in_active = 5'b10001;
        @(negedge clk);
        in_active = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t2 order b", out_sel, seq_b[i]);
        end

        // 3 backpressure with overwrite
        do_reset();
        out_ready = 1'b0;
        set_frame(3, pat(8'h31));
        in_active = 5'b01000;
        ets = tb_tick;
        @(negedge clk);
        in_active = '0;
        @(negedge clk);
        check("t3 valid", out_valid, 1);
        check("t3 sel", out_sel, 5'b01000);
        errs = 0;
        ets3 = 0;
        for (int c = 0; c < 20; c++) begin
            if (c == 5) begin
                set_frame(3, pat(8'h32));
                in_active = 5'b01000;
            end else if (c == 10) begin
                set_frame(3, pat(8'h33));
                in_active = 5'b01000;
                ets3 = tb_tick;
            end else begin
                in_active = '0;
            end
            @(negedge clk);
            if (out_valid !== 1'b1 || out_sel !== 5'b01000 || out_frame !== pat(8'h31) || out_ts !== TW'(ets))
                errs++;
        end
        check("t3 stable", errs, 0);
        check("t3 drop", drop_count, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("t3 xfer valid", out_valid, 0);
        @(negedge clk);
        check("t3 next sel", out_sel, 5'b01000);
        check("t3 next frame", out_frame, pat(8'h33));
        check("t3 next ts", out_ts, ets3);
        @(negedge clk);
        check("t3 busy end", busy, 0);

        // 4 same-edge load and capture
        do_reset();
        out_ready = 1'b0;
        set_frame(1, pat(8'h41));
        in_active = 5'b00010;
        @(negedge clk);
        set_frame(1, pat(8'h42));
        in_active = 5'b00010;
        @(negedge clk);
        in_active = '0;
        check("t4 old frame", out_frame, pat(8'h41));
        check("t4 sel", out_sel, 5'b00010);
        check("t4 drop", drop_count, 0);
        out_ready = 1'b1;
        @(negedge clk);
        check("t4 gap valid", out_valid, 0);
        check("t4 gap busy", busy, 1);
        @(negedge clk);
        check("t4 new frame", out_frame, pat(8'h42));
        check("t4 drop after", drop_count, 0);
        @(negedge clk);
        check("t4 busy end", busy, 0);

        // 5 tick wrap and drop saturation on narrow instance
        do_reset();
        out_ready2 = 1'b1;
        for (int k = 0; k < 100 && !(tb_tick >= 16 && (tb_tick % 16) == 15); k++) @(negedge clk);
        in_frame2[0*FW2 +: FW2] = 16'h5A00;
        in_active2 = 5'b00001;
        @(negedge clk);
        in_frame2[1*FW2 +: FW2] = 16'h5A01;
        in_active2 = 5'b00010;
        @(negedge clk);
        in_active2 = '0;
        check("t5 ts max", out_ts2, 15);
        check("t5 sel0", out_sel2, 5'b00001);
        @(negedge clk);
        @(negedge clk);
        check("t5 ts wrap", out_ts2, 0);
        check("t5 sel1", out_sel2, 5'b00010);
        check("t5 frame1", out_frame2, 16'h5A01);
        @(negedge clk);
        check("t5 valid off", out_valid2, 0);
        out_ready2 = 1'b0;
        in_frame2[2*FW2 +: FW2] = 16'h5A02;
        for (int k = 0; k < 7; k++) begin
            in_active2 = 5'b00100;
            @(negedge clk);
            check("t5 drop sat", drop_count2, sat_exp[k]);
        end
        in_active2 = '0;

        // 6 reset while presenting with pending slots
        do_reset();
        out_ready = 1'b0;
        set_frame(0, pat(8'h60));
        set_frame(1, pat(8'h61));
        set_frame(2, pat(8'h62));
        in_active = 5'b00111;
        @(negedge clk);
        set_frame(1, pat(8'h63));
        in_active = 5'b00010;
        @(negedge clk);
        in_active = '0;
        check("t6 pre sel", out_sel, 5'b00001);
        check("t6 pre drop", drop_count, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("t6 valid", out_valid, 0);
        check("t6 busy", busy, 0);
        check("t6 drop", drop_count, 0);
        check("t6 sel", out_sel, 0);
        check("t6 frame", out_frame, 0);
        set_frame(2, pat(8'h64));
        in_active = 5'b00100;
        out_ready = 1'b1;
        @(negedge clk);
        in_active = '0;
        @(negedge clk);
        check("t6 post sel", out_sel, 5'b00100);
        check("t6 post frame", out_frame, pat(8'h64));
        @(negedge clk);
        check("t6 post busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
